// File: rtl/shift_add_mult_ctrl_if.sv
// Operand/result handshake bundle for the shift-and-add multiplier.
// Master is the operand source; slave is the multiplier controller.
interface shift_add_mult_ctrl_if #(
  parameter int WIDTH = 12
);
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               ready;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  ready,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output ready,
    output busy,
    output done,
    output product
  );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-and-add multiplier: WIDTH iterations, then a one-cycle
// done pulse with the 2*WIDTH-bit product held until the next accept.
module shift_add_mult_ctrl #(
  parameter int WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  shift_add_mult_ctrl_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   acc, acc_n;
  logic [PW-1:0]   mcand, mcand_n;
  logic [PW-1:0]   product, product_n;
  logic [WIDTH-1:0] mplr, mplr_n;
  logic [CW-1:0]   count, count_n;
  logic [PW-1:0]   acc_add;

  assign acc_add = mplr[0] ? acc + mcand : acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      mcand   <= mcand_n;
      mplr    <= mplr_n;
      count   <= count_n;
      product <= product_n;
    end
  end

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    mcand_n   = mcand;
    mplr_n    = mplr;
    count_n   = count;
    product_n = product;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          mcand_n = PW'(bus.multiplicand);
          mplr_n  = bus.multiplier;
          acc_n   = '0;
          count_n = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        acc_n   = acc_add;
        mcand_n = {mcand[PW-2:0], 1'b0};
        mplr_n  = mplr >> 1;
        count_n = count + 1'b1;
        // Last iteration: the product register takes the final sum directly.
        if (count == CW'(WIDTH - 1)) begin
          state_n   = DONE;
          product_n = acc_add;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.ready   = (state == IDLE);
  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.product = product;
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed-vector and corner-sequence bench for shift_add_mult_ctrl.
// Drives after the rising edge, samples on the falling edge.
module tb_shift_add_mult_ctrl;
  localparam int W = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  shift_add_mult_ctrl_if #(.WIDTH(W)) bus ();

  shift_add_mult_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    string          nm;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [47:0] act,
                     input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One full transaction: accept, count edges to done, check timing and result.
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input string nm);
    int  edges;
    int  busy_n;
    bit  seen;
    int  waits;
    waits = 0;
    @(negedge clk);
    while (!bus.ready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    chk({nm, "_ready_before"}, bus.ready, 1);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    bus.multiplicand = W'($urandom);
    bus.multiplier   = W'($urandom);
    edges  = 0;
    busy_n = 0;
    seen   = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen  = 1;
        edges = k + 1;
      end else if (bus.busy) begin
        busy_n++;
      end
    end
    chk({nm, "_latency"}, edges, W + 1);
    chk({nm, "_busy_cycles"}, busy_n, W);
    chk({nm, "_product"}, bus.product, exp);
    @(negedge clk);
    chk({nm, "_done_width"}, bus.done, 0);
    chk({nm, "_ready_after"}, bus.ready, 1);
    chk({nm, "_product_held"}, bus.product, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    logic [2*W-1:0] cap;
    int cyc;
    int n;
    int tdone[3];
    logic [W-1:0] ra, rb;
    logic [2*W-1:0] bb_exp[3];

    tbl[0] = '{12'd5,   12'd3,   24'h00000F, "a5b3"};
    tbl[1] = '{12'hFFF, 12'hFFF, 24'hFFE001, "max"};
    tbl[2] = '{12'hF0C, 12'hAC2, 24'hA1DF18, "mix"};
    tbl[3] = '{12'h000, 12'h7FF, 24'h000000, "a0"};
    tbl[4] = '{12'h123, 12'h000, 24'h000000, "b0"};
    tbl[5] = '{12'h800, 12'h800, 24'h400000, "msb"};
    tbl[6] = '{12'h001, 12'hABC, 24'h000ABC, "one"};
    tbl[7] = '{12'h555, 12'h003, 24'h000FFF, "alt"};

    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_product", bus.product, 0);
    reset_n = 1'b1;

    foreach (tbl[i]) run_mult(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].nm);

    // Start pulsed during RUN with new operands must be ignored.
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 12'd7;
    bus.multiplier   = 12'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 12'd2;
    bus.multiplier   = 12'd2;
    @(negedge clk);
    bus.start        = 1'b0;
    bus.multiplicand = 12'hABC;
    bus.multiplier   = 12'h321;
    dones = 0;
    cap   = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        cap = bus.product;
      end
    end
    chk("ign_done_count", dones, 1);
    chk("ign_product", cap, 24'h00003F);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 12'hFFF;
    bus.multiplier   = 12'hFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ready", bus.ready, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_product", bus.product, 0);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("arst_no_done", dones, 0);
    run_mult(12'd3, 12'd4, 24'h00000C, "post_rst");

    // start held high: back-to-back multiplies.
    bb_exp[0] = 24'd1;
    bb_exp[1] = 24'd4;
    bb_exp[2] = 24'd9;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 12'd1;
    bus.multiplier   = 12'd1;
    n   = 0;
    cyc = 0;
    for (int k = 0; k < 100 && n < 3; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        tdone[n] = cyc;
        chk($sformatf("b2b_product%0d", n), bus.product, bb_exp[n]);
        n++;
        bus.multiplicand = W'(n + 1);
        bus.multiplier   = W'(n + 1);
        if (n == 3) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("b2b_done_count", n, 3);
    if (n == 3) begin
      chk("b2b_space01", tdone[1] - tdone[0], W + 2);
      chk("b2b_space12", tdone[2] - tdone[1], W + 2);
    end

    for (int r = 0; r < 1000; r++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_mult(ra, rb, (2*W)'(ra) * (2*W)'(rb), $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
